// File: rtl/ped_request_scheduler_if.sv
// Pedestrian scheduler bus: raw walk buttons in, walk-phase handshake to the
// light controller, and WAIT lamp / status outputs.
interface ped_request_scheduler_if;
    logic [3:0] WB;
    logic       serve_ack;
    logic       serve_done;
    logic       serve_req;
    logic [1:0] serve_id;
    logic       serve_urgent;
    logic [3:0] pending;
    logic       busy;

    // Side that drives the buttons and the controller handshake responses.
    modport master (
        output WB, serve_ack, serve_done,
        input  serve_req, serve_id, serve_urgent, pending, busy
    );

    // Scheduler side.
    modport slave (
        input  WB, serve_ack, serve_done,
        output serve_req, serve_id, serve_urgent, pending, busy
    );
endinterface

// File: rtl/ped_request_scheduler.sv
// Pedestrian walk-request scheduler: debounces and latches four walk buttons,
// ages pending requests, arbitrates round-robin with a starvation override,
// and hands one crossing at a time to the light controller over req/ack/done.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | no crossing granted; arbitrate among pending requests
//  S_REQ   | serve_req high, waiting for the controller to accept
//  S_SERVE | walk phase running for serve_id, waiting for serve_done
module ped_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT        = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    ped_request_scheduler_if.slave  bus
);

    localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_deb_cnt [4];
    logic [3:0]    r_deb_lvl;
    logic [3:0]    r_pending;
    logic [AW-1:0] r_age [4];
    logic [1:0]    r_last_grant;
    logic          r_serve_req;
    logic [1:0]    r_serve_id;
    logic          r_serve_urgent;
    logic          r_busy;

    logic [DW-1:0] w_cnt_next [4];
    logic [3:0]    w_lvl_next;
    logic [3:0]    w_press;
    logic [3:0]    w_id_onehot;
    logic          w_ack_taken;
    logic [3:0]    w_press_block;
    logic [3:0]    w_ack_clr;
    logic [3:0]    w_pending_next;
    logic [3:0]    w_urgent;
    logic [3:0]    w_urgent_pend;
    logic [3:0]    w_cand;
    logic [1:0]    w_rr_idx;
    logic [1:0]    w_pick;
    logic          w_found;

    // Debounce next-state: the press is recognised on the same edge the
    // counter reaches its threshold, so pending follows that edge directly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cnt_next[i] = '0;
            if (bus.WB[i]) begin
                if (r_deb_cnt[i] == DEB_MAX)
                    w_cnt_next[i] = DEB_MAX;
                else
                    w_cnt_next[i] = r_deb_cnt[i] + DW'(1);
            end
            w_lvl_next[i] = (w_cnt_next[i] == DEB_MAX);
        end
        w_press = w_lvl_next & ~r_deb_lvl;
    end

    // Press masking and pending update. A press on the crossing being served
    // (or being acked this cycle) is dropped: that walk is already happening.
    always_comb begin
        w_id_onehot    = 4'b0001 << r_serve_id;
        w_ack_taken    = (r_state == S_REQ) && bus.serve_ack;
        w_ack_clr      = w_ack_taken ? w_id_onehot : 4'b0000;
        w_press_block  = ((r_state == S_SERVE) || w_ack_taken) ? w_id_onehot : 4'b0000;
        w_pending_next = (r_pending | (w_press & ~w_press_block)) & ~w_ack_clr;
    end

    // Urgency and candidate set: urgent requests pre-empt plain round-robin.
    always_comb begin
        for (int i = 0; i < 4; i++)
            w_urgent[i] = (r_age[i] == AGE_MAX);
        w_urgent_pend = w_urgent & r_pending;
        w_cand        = (|w_urgent_pend) ? w_urgent_pend : r_pending;
    end

    // Round-robin search starting one past the last served crossing.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = 2'd0;
        w_rr_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_rr_idx = r_last_grant + 2'(k + 1);
            if (!w_found && w_cand[w_rr_idx]) begin
                w_found = 1'b1;
                w_pick  = w_rr_idx;
            end
        end
    end

    // Debounce counters and debounced levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                r_deb_cnt[i] <= '0;
            r_deb_lvl <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++)
                r_deb_cnt[i] <= w_cnt_next[i];
            r_deb_lvl <= w_lvl_next;
        end
    end

    // Latched requests (WAIT lamps).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pending <= 4'b0000;
        else
            r_pending <= w_pending_next;
    end

    // Request ages: count while pending, saturate at MAX_WAIT, clear when served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                r_age[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_pending[i] || w_ack_clr[i])
                    r_age[i] <= '0;
                else if (r_age[i] != AGE_MAX)
                    r_age[i] <= r_age[i] + AW'(1);
            end
        end
    end

    // Grant FSM and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 2'd3;
            r_serve_req    <= 1'b0;
            r_serve_id     <= 2'd0;
            r_serve_urgent <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_serve_id     <= w_pick;
                        r_serve_urgent <= w_urgent[w_pick];
                        r_serve_req    <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.serve_ack) begin
                        r_serve_req <= 1'b0;
                        r_state     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (bus.serve_done) begin
                        r_last_grant <= r_serve_id;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_serve_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.serve_req    = r_serve_req;
    assign bus.serve_id     = r_serve_id;
    assign bus.serve_urgent = r_serve_urgent;
    assign bus.pending      = r_pending;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Directed bench for the pedestrian request scheduler.
module tb_ped_request_scheduler;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    ped_request_scheduler_if bus();

    ped_request_scheduler #(
        .DEBOUNCE_CYCLES (4),
        .MAX_WAIT        (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.serve_req, bus.serve_id, bus.serve_urgent, bus.pending, bus.busy};
    endfunction

    task automatic press(input logic [3:0] mask);
        bus.WB = mask;
        tick(4);
        bus.WB = 4'b0000;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30; i++) begin
            if (bus.serve_req) break;
            tick();
        end
        check("req_seen", 32'(bus.serve_req), 32'd1);
    endtask

    // Wait for a grant, ack it two cycles in, pulse done ten cycles after ack.
    task automatic serve_one(input logic [1:0] exp_id, input logic exp_urg);
        wait_req();
        check("grant_id", 32'(bus.serve_id), 32'(exp_id));
        check("grant_urgent", 32'(bus.serve_urgent), 32'(exp_urg));
        check("grant_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.serve_ack = 1'b1;
        tick();
        bus.serve_ack = 1'b0;
        check("ack_req_low", 32'(bus.serve_req), 32'd0);
        check("ack_pend_clr", 32'(bus.pending[exp_id]), 32'd0);
        tick(9);
        bus.serve_done = 1'b1;
        tick();
        bus.serve_done = 1'b0;
        check("done_busy_low", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.WB = 4'hF;
        bus.serve_ack = 1'b0;
        bus.serve_done = 1'b0;

        // reset held with all buttons pressed
        tick(2);
        check("rst_outs", 32'(outs()), 32'd0);
        bus.WB = 4'h0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_idle", 32'(outs()), 32'd0);
        end

        // debounce: too short a press is ignored
        bus.WB = 4'b0010;
        tick(3);
        check("short_press", 32'(bus.pending), 32'd0);
        bus.WB = 4'b0000;
        tick();
        check("short_release", 32'(bus.pending), 32'd0);

        // debounce: valid press, held long
        bus.WB = 4'b0010;
        tick(3);
        check("press_3edges", 32'(bus.pending), 32'd0);
        tick();
        check("press_4edges", 32'(bus.pending), 32'b0010);
        check("press_no_req_yet", 32'(bus.serve_req), 32'd0);
        tick();
        check("grant1_req", 32'({bus.serve_req, bus.serve_id, bus.busy}), 32'b1011);
        tick();
        bus.serve_ack = 1'b1;
        tick();
        bus.serve_ack = 1'b0;
        check("grant1_ack", 32'({bus.serve_req, bus.pending, bus.busy}), 32'b000001);
        tick(3);
        bus.serve_done = 1'b1;
        tick();
        bus.serve_done = 1'b0;
        check("grant1_done", 32'(bus.busy), 32'd0);
        tick(5);
        check("held_no_retrigger", 32'({bus.serve_req, bus.pending}), 32'd0);
        bus.WB = 4'b0000;

        // round-robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        press(4'hF);
        check("rr_all_pending", 32'(bus.pending), 32'hF);
        serve_one(2'd0, 1'b0);
        serve_one(2'd1, 1'b0);
        serve_one(2'd2, 1'b0);
        serve_one(2'd3, 1'b0);
        press(4'b0101);
        check("rr_02_pending", 32'(bus.pending), 32'b0101);
        serve_one(2'd0, 1'b0);
        serve_one(2'd2, 1'b0);

        // handshake hold on crossing 0, with presses aging behind it
        press(4'b0001);
        wait_req();
        check("hold_id0", 32'(bus.serve_id), 32'd0);
        for (int i = 0; i < 100; i++) begin
            bus.WB = ((i >= 10 && i < 14) ? 4'b1000 : 4'b0000) |
                     ((i >= 80 && i < 84) ? 4'b0010 : 4'b0000);
            bus.serve_done = (i == 20 || i == 50);
            tick();
            check("hold_stable", 32'({bus.serve_req, bus.serve_id, bus.busy}), 32'b1001);
        end
        bus.WB = 4'b0000;
        bus.serve_done = 1'b0;
        check("hold_pending", 32'(bus.pending), 32'b1011);
        bus.serve_ack = 1'b1;
        tick();
        bus.serve_ack = 1'b0;
        check("hold_ack_pending", 32'(bus.pending), 32'b1010);
        bus.serve_done = 1'b1;
        tick();
        bus.serve_done = 1'b0;
        check("hold_done_busy", 32'(bus.busy), 32'd0);
        serve_one(2'd3, 1'b1);
        serve_one(2'd1, 1'b0);

        // presses during SERVE: served crossing discarded, others latch
        press(4'b0100);
        wait_req();
        check("sim_id2", 32'(bus.serve_id), 32'd2);
        tick();
        bus.serve_ack = 1'b1;
        tick();
        bus.serve_ack = 1'b0;
        press(4'b0110);
        check("sim_pending", 32'(bus.pending), 32'b0010);
        bus.serve_done = 1'b1;
        tick();
        bus.serve_done = 1'b0;
        tick();
        check("sim_req1", 32'({bus.serve_req, bus.serve_id}), 32'b101);

        // async reset in REQ
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({bus.serve_req, bus.pending, bus.busy}), 32'd0);
        tick();
        rst = 1'b0;
        tick(3);
        check("rst_lost_req", 32'(outs()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
